// File: rtl/l2_line_adapter.sv
// Line-to-burst adapter: one 256-bit L2 line <-> BURSTS beats of BURST_WIDTH on the memory bus.
// Latency: request edge -> beats on the next BURSTS edges (resp_i stalls stretch this) -> resp_o pulse one cycle later.
// Backpressure: resp_i low holds the current beat; L2_ADAPTER_TIMEOUT_EN adds a watchdog that aborts with error_o.
module l2_line_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic                   resp_i,
    output logic                   error_o
);

    localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int OFF    = $clog2(LINE_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(BURSTS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DONE = 3'd2,
        WR      = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wline_q, wline_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic                    active;
    logic                    timeout_hit;
    logic                    unused_addr_lsb;

    assign addr_aligned    = {address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign unused_addr_lsb = ^address_i[OFF-1:0];
    assign active          = (state_q == RD) || (state_q == WR);

`ifdef L2_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;

    // A beat arriving on the limit edge wins over the watchdog.
    assign timeout_hit = active && !resp_i && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        timer_d = '0;
        if (active && !resp_i) begin
            timer_d = timer_q + 1'b1;
        end
        error_d = error_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WR;
                end else if (read_i) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (timeout_hit || (resp_i && count_q == LAST)) begin
                    state_d = RD_DONE;
                end
            end
            WR: begin
                if (timeout_hit || (resp_i && count_q == LAST)) begin
                    state_d = WR_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_o    = (state_q == RD);
        write_o   = (state_q == WR);
        resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
        address_o = addr_q;
        line_o    = line_q;
        burst_o   = '0;
        if (state_q == WR) begin
            burst_o = wline_q[int'(count_q)*BURST_WIDTH +: BURST_WIDTH];
        end
`ifdef L2_ADAPTER_TIMEOUT_EN
        error_o   = error_q;
`else
        error_o   = 1'b0;
`endif
    end

    // Datapath: address/write line captured in IDLE, read beats merged into line_q.
    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (write_i || read_i) begin
                    addr_d = addr_aligned;
                end
                if (write_i) begin
                    wline_d = line_i;
                end
            end
            RD: begin
                if (resp_i) begin
                    line_d[int'(count_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                if (timeout_hit) begin
                    count_d = '0;
                end
            end
            WR: begin
                if (resp_i) begin
                    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                if (timeout_hit) begin
                    count_d = '0;
                end
            end
            default: count_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
        end
    end

endmodule
